// File: rtl/rf_dispatch_controller_pkg.sv
// rtl/rf_dispatch_controller_pkg.sv - shared frontend uop kinds and dispatch FSM states
//
// Purpose: constants shared between decode and the register-file dispatch
//          controller. Holds the uop kind encodings and the dispatch FSM
//          state encoding.
// Ports:   none (package).
package rf_dispatch_controller_pkg;

  localparam int unsigned UOP_COMMAND_KIND_NOP  = 0;
  localparam int unsigned UOP_COMMAND_KIND_IMM  = 1;
  localparam int unsigned UOP_COMMAND_KIND_COPY = 2;
  localparam int unsigned UOP_COMMAND_KIND_ALU  = 3;

  typedef enum logic {
    DISPATCH_IDLE  = 1'b0,
    DISPATCH_ISSUE = 1'b1
  } dispatch_state_e;

endpackage

// File: rtl/rf_dispatch_controller_rr_arbiter.sv
// rtl/rf_dispatch_controller_rr_arbiter.sv - round-robin one-hot grant over EU ready lines
//
// Purpose: picks the first ready EU starting at the round-robin pointer and
//          wrapping upward; grant is all zero when nothing is ready.
// Ports:
//   ready  in  N      per-EU ready
//   ptr    in  PTR_W  search start index
//   grant  out N      one-hot grant (or zero)
module dispatch_rr_arbiter
  import rf_dispatch_controller_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     ready,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int off = 0; off < N; off++) begin
      if (!found && ready[(int'(ptr) + off) % N]) begin
        grant[(int'(ptr) + off) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_dispatch_controller.sv
// rtl/rf_dispatch_controller.sv - register file with CDB snoop and round-robin ALU uop dispatch
//
// Purpose: holds architectural registers as {value, valid} (value is a
//          pending CDB tag when valid=0), executes IMM/COPY locally and
//          dispatches ALU uops to one of EU_COUNT execution units.
// Ports:
//   clk, rst                          clock, async active-high reset
//   cdb_in_valid/tag/data             result broadcast snooped by regs and hold operands
//   cmd_valid/cmd_ready               uop handshake from decode
//   cmd_kind/cmd_op1/cmd_op2          uop fields
//   eu_issue_valid/eu_issue_ready     one-hot issue handshake per EU
//   eu_result_tag                     tag each EU assigns to an accepted uop
//   eu_op_a/b_data, eu_op_a/b_valid   shared operand bus (data or pending tag)
module rf_dispatch_controller
  import rf_dispatch_controller_pkg::*;
#(
  parameter int REGISTER_COUNT    = 8,
  parameter int DATA_WIDTH        = 4,
  parameter int CDB_TAG_WIDTH     = 4,
  parameter int UOP_COMMAND_WIDTH = 3,
  parameter int EU_COUNT          = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cdb_in_valid,
  input  logic [CDB_TAG_WIDTH-1:0]             cdb_in_tag,
  input  logic [DATA_WIDTH-1:0]                cdb_in_data,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [UOP_COMMAND_WIDTH-1:0]         cmd_kind,
  input  logic [$clog2(REGISTER_COUNT)-1:0]    cmd_op1,
  input  logic [((DATA_WIDTH > $clog2(REGISTER_COUNT)) ? DATA_WIDTH : $clog2(REGISTER_COUNT))-1:0] cmd_op2,
  output logic [EU_COUNT-1:0]                  eu_issue_valid,
  input  logic [EU_COUNT-1:0]                  eu_issue_ready,
  input  logic [EU_COUNT*CDB_TAG_WIDTH-1:0]    eu_result_tag,
  output logic [DATA_WIDTH-1:0]                eu_op_a_data,
  output logic [DATA_WIDTH-1:0]                eu_op_b_data,
  output logic                                 eu_op_a_valid,
  output logic                                 eu_op_b_valid
);

  localparam int IDX_W = $clog2(REGISTER_COUNT);
  localparam int PTR_W = (EU_COUNT > 1) ? $clog2(EU_COUNT) : 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] value;
    logic                  valid;
  } rf_entry_t;

  rf_entry_t       rf_q     [REGISTER_COUNT];
  rf_entry_t       rf_d     [REGISTER_COUNT];
  rf_entry_t       rf_snoop [REGISTER_COUNT];
  rf_entry_t       hold_a_q, hold_a_d;
  rf_entry_t       hold_b_q, hold_b_d;
  rf_entry_t       src_a, src_b;
  dispatch_state_e state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  logic [EU_COUNT-1:0]      grant;
  logic [CDB_TAG_WIDTH-1:0] grant_tag;
  logic [PTR_W-1:0]         grant_next_ptr;
  logic [DATA_WIDTH-1:0]    cdb_tag_ext;
  logic [IDX_W-1:0]         op2_idx;
  logic                     issuing;

  assign cdb_tag_ext = DATA_WIDTH'(cdb_in_tag);
  assign op2_idx     = cmd_op2[IDX_W-1:0];
  assign issuing     = (state_q == DISPATCH_ISSUE);

  // An entry waiting on a tag resolves when the CDB broadcasts that tag.
  function automatic rf_entry_t snoop(input rf_entry_t e);
    if (cdb_in_valid && !e.valid && (e.value == cdb_tag_ext))
      return {cdb_in_data, 1'b1};
    return e;
  endfunction

  // Snooped view doubles as the same-cycle bypass for COPY/ALU reads.
  always_comb begin
    for (int r = 0; r < REGISTER_COUNT; r++) rf_snoop[r] = snoop(rf_q[r]);
  end

  assign src_a = rf_snoop[cmd_op1];
  assign src_b = rf_snoop[op2_idx];

  dispatch_rr_arbiter #(
    .N     (EU_COUNT),
    .PTR_W (PTR_W)
  ) u_arb (
    .ready (eu_issue_ready),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    grant_tag      = '0;
    grant_next_ptr = '0;
    for (int i = 0; i < EU_COUNT; i++) begin
      if (grant[i]) begin
        grant_tag      = eu_result_tag[i*CDB_TAG_WIDTH +: CDB_TAG_WIDTH];
        grant_next_ptr = PTR_W'((i + 1) % EU_COUNT);
      end
    end
  end

  // Write-port updates are applied after the snoop defaults so they win collisions.
  always_comb begin
    for (int r = 0; r < REGISTER_COUNT; r++) rf_d[r] = rf_snoop[r];
    hold_a_d = snoop(hold_a_q);
    hold_b_d = snoop(hold_b_q);
    state_d  = state_q;
    ptr_d    = ptr_q;
    if (state_q == DISPATCH_IDLE) begin
      if (cmd_valid) begin
        if (cmd_kind == UOP_COMMAND_WIDTH'(UOP_COMMAND_KIND_IMM)) begin
          rf_d[0] = {cmd_op2[DATA_WIDTH-1:0], 1'b1};
        end else if (cmd_kind == UOP_COMMAND_WIDTH'(UOP_COMMAND_KIND_COPY)) begin
          rf_d[op2_idx] = src_a;
        end else if (cmd_kind == UOP_COMMAND_WIDTH'(UOP_COMMAND_KIND_ALU)) begin
          hold_a_d = src_a;
          hold_b_d = src_b;
          state_d  = DISPATCH_ISSUE;
        end
      end
    end else if (|grant) begin
      // grant is already masked by ready, so any bit set is a transfer.
      rf_d[0] = {DATA_WIDTH'(grant_tag), 1'b0};
      ptr_d   = grant_next_ptr;
      state_d = DISPATCH_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < REGISTER_COUNT; r++) rf_q[r] <= {{DATA_WIDTH{1'b0}}, 1'b1};
      hold_a_q <= {{DATA_WIDTH{1'b0}}, 1'b1};
      hold_b_q <= {{DATA_WIDTH{1'b0}}, 1'b1};
      state_q  <= DISPATCH_IDLE;
      ptr_q    <= '0;
    end else begin
      for (int r = 0; r < REGISTER_COUNT; r++) rf_q[r] <= rf_d[r];
      hold_a_q <= hold_a_d;
      hold_b_q <= hold_b_d;
      state_q  <= state_d;
      ptr_q    <= ptr_d;
    end
  end

  assign cmd_ready      = (state_q == DISPATCH_IDLE);
  assign eu_issue_valid = issuing ? grant : '0;
  assign eu_op_a_data   = issuing ? hold_a_q.value : '0;
  assign eu_op_a_valid  = issuing ? hold_a_q.valid : 1'b0;
  assign eu_op_b_data   = issuing ? hold_b_q.value : '0;
  assign eu_op_b_valid  = issuing ? hold_b_q.valid : 1'b0;

endmodule

// File: tb/tb_rf_dispatch_controller.sv
// tb/tb_rf_dispatch_controller.sv - scoreboard bench for rf_dispatch_controller
module tb_rf_dispatch_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       cdb_in_valid;
  logic [3:0] cdb_in_tag;
  logic [3:0] cdb_in_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_kind;
  logic [2:0] cmd_op1;
  logic [3:0] cmd_op2;
  logic [1:0] eu_issue_valid;
  logic [1:0] eu_issue_ready;
  logic [7:0] eu_result_tag;
  logic [3:0] eu_op_a_data;
  logic [3:0] eu_op_b_data;
  logic       eu_op_a_valid;
  logic       eu_op_b_valid;

  localparam logic [2:0] K_NOP = 3'd0, K_IMM = 3'd1, K_COPY = 3'd2, K_ALU = 3'd3;

  typedef struct packed {
    logic [1:0] grant;
    logic [3:0] a;
    logic       a_v;
    logic [3:0] b;
    logic       b_v;
  } xfer_t;

  xfer_t exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  rf_dispatch_controller dut (
    .clk            (clk),
    .rst            (rst),
    .cdb_in_valid   (cdb_in_valid),
    .cdb_in_tag     (cdb_in_tag),
    .cdb_in_data    (cdb_in_data),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_kind       (cmd_kind),
    .cmd_op1        (cmd_op1),
    .cmd_op2        (cmd_op2),
    .eu_issue_valid (eu_issue_valid),
    .eu_issue_ready (eu_issue_ready),
    .eu_result_tag  (eu_result_tag),
    .eu_op_a_data   (eu_op_a_data),
    .eu_op_b_data   (eu_op_b_data),
    .eu_op_a_valid  (eu_op_a_valid),
    .eu_op_b_valid  (eu_op_b_valid)
  );

  always #5 clk = ~clk;

  function automatic xfer_t mk(input logic [1:0] g, input logic [3:0] a, input logic av,
                               input logic [3:0] b, input logic bv);
    return {g, a, av, b, bv};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic send(input logic [2:0] kind, input logic [2:0] op1, input logic [3:0] op2,
                      input logic cv = 1'b0, input logic [3:0] ct = 4'd0, input logic [3:0] cd = 4'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_kind = kind; cmd_op1 = op1; cmd_op2 = op2;
    cdb_in_valid = cv; cdb_in_tag = ct; cdb_in_data = cd;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cdb_in_valid = 1'b0;
  endtask

  task automatic cdb_pulse(input logic [3:0] t, input logic [3:0] d);
    @(posedge clk); #1;
    cdb_in_valid = 1'b1; cdb_in_tag = t; cdb_in_data = d;
    @(posedge clk); #1;
    cdb_in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(cmd_ready), 32'd1);
  endtask

  // Monitor: every transfer seen on the issue port is checked against the queue.
  initial begin
    xfer_t act, expv;
    forever begin
      @(negedge clk);
      if (!rst && |(eu_issue_valid & eu_issue_ready)) begin
        act = {eu_issue_valid, eu_op_a_data, eu_op_a_valid, eu_op_b_data, eu_op_b_valid};
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_xfer: got 0x%0h, expected no transfer", act);
        end else begin
          expv = exp_q.pop_front();
          check("xfer{grant,a,av,b,bv}", 32'(act), 32'(expv));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cdb_in_valid = 1'b0; cdb_in_tag = '0; cdb_in_data = '0;
    cmd_valid = 1'b0; cmd_kind = '0; cmd_op1 = '0; cmd_op2 = '0;
    eu_issue_ready = 2'b00; eu_result_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_issue_valid", 32'(eu_issue_valid), 32'd0);
    check("rst_op_a_data", 32'(eu_op_a_data), 32'd0);
    check("rst_op_a_valid", 32'(eu_op_a_valid), 32'd0);
    check("rst_op_b_data", 32'(eu_op_b_data), 32'd0);
    check("rst_op_b_valid", 32'(eu_op_b_valid), 32'd0);

    // IMM 5, COPY r0->r3, read both through EU0.
    send(K_IMM, 3'd0, 4'd5);
    check("imm_cmd_ready", 32'(cmd_ready), 32'd1);
    send(K_COPY, 3'd0, 4'd3);
    eu_issue_ready = 2'b01; eu_result_tag = {4'd2, 4'd1};
    exp_q.push_back(mk(2'b01, 4'd5, 1'b1, 4'd5, 1'b1));
    send(K_ALU, 3'd0, 4'd3);
    wait_idle("idle_imm_copy");          // ACC={1,0}, ptr=1

    // EU0 not ready, EU1 ready with tag 9.
    eu_issue_ready = 2'b10; eu_result_tag = {4'd9, 4'd1};
    exp_q.push_back(mk(2'b10, 4'd0, 1'b1, 4'd0, 1'b1));
    send(K_ALU, 3'd1, 4'd2);
    wait_idle("idle_eu1");               // ACC={9,0}, ptr=0

    // Both ready: pointer 0 picks EU0; ACC read shows pending tag 9.
    eu_issue_ready = 2'b11; eu_result_tag = {4'd9, 4'd9};
    exp_q.push_back(mk(2'b01, 4'd9, 1'b0, 4'd5, 1'b1));
    send(K_ALU, 3'd0, 4'd3);
    wait_idle("idle_ptr0");              // ACC={9,0}, ptr=1

    // Registers resolve a pending tag from the CDB.
    send(K_COPY, 3'd0, 4'd6);            // r6={9,0}
    cdb_pulse(4'd9, 4'd7);               // r0,r6 -> {7,1}
    exp_q.push_back(mk(2'b10, 4'd7, 1'b1, 4'd7, 1'b1));
    send(K_ALU, 3'd6, 4'd0);
    wait_idle("idle_snoop");             // ACC={9,0}, ptr=0

    // Same-cycle bypass of CDB into an ALU read of r0.
    eu_result_tag = {4'd9, 4'd8};
    exp_q.push_back(mk(2'b01, 4'd7, 1'b1, 4'd0, 1'b1));
    send(K_ALU, 3'd0, 4'd2, 1'b1, 4'd9, 4'd7);
    wait_idle("idle_bypass");            // ACC={8,0}, ptr=1

    // Stall in ISSUE while the held operand resolves from the CDB.
    eu_issue_ready = 2'b00; eu_result_tag = {4'd2, 4'd8};
    exp_q.push_back(mk(2'b10, 4'd3, 1'b1, 4'd5, 1'b1));
    send(K_ALU, 3'd0, 4'd3);
    check("stall_op_a_tag", 32'(eu_op_a_data), 32'd8);
    check("stall_op_a_pending", 32'(eu_op_a_valid), 32'd0);
    for (int c = 0; c < 3; c++) begin
      check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      check("stall_issue_valid", 32'(eu_issue_valid), 32'd0);
      if (c == 1) begin
        cdb_in_valid = 1'b1; cdb_in_tag = 4'd8; cdb_in_data = 4'd3;
      end
      @(posedge clk); #1;
      cdb_in_valid = 1'b0;
    end
    check("stall_op_a_data", 32'(eu_op_a_data), 32'd3);
    check("stall_op_a_valid", 32'(eu_op_a_valid), 32'd1);
    eu_issue_ready = 2'b10;
    wait_idle("idle_stall");             // ACC={2,0}, ptr=0

    // Transfer write to ACC collides with a CDB hit on ACC's tag: write wins.
    eu_issue_ready = 2'b00; eu_result_tag = {4'd12, 4'd11};
    exp_q.push_back(mk(2'b01, 4'd5, 1'b1, 4'd5, 1'b1));
    send(K_ALU, 3'd3, 4'd3);
    eu_issue_ready = 2'b01; cdb_in_valid = 1'b1; cdb_in_tag = 4'd2; cdb_in_data = 4'd4;
    @(posedge clk); #1;
    cdb_in_valid = 1'b0;
    wait_idle("idle_collide");           // ACC={11,0}, ptr=1
    eu_issue_ready = 2'b11;
    exp_q.push_back(mk(2'b10, 4'd11, 1'b0, 4'd5, 1'b1));
    send(K_ALU, 3'd0, 4'd3);
    wait_idle("idle_collide_read");      // ACC={12,0}, ptr=0

    // NOP and an unknown kind change nothing.
    send(K_NOP, 3'd1, 4'd5);
    check("nop_cmd_ready", 32'(cmd_ready), 32'd1);
    send(3'd7, 3'd0, 4'd3);
    check("unknown_cmd_ready", 32'(cmd_ready), 32'd1);
    eu_issue_ready = 2'b01; eu_result_tag = {4'd12, 4'd13};
    exp_q.push_back(mk(2'b01, 4'd12, 1'b0, 4'd5, 1'b1));
    send(K_ALU, 3'd0, 4'd3);
    wait_idle("idle_nop");               // ACC={13,0}, ptr=1

    // Reset while a uop is held in ISSUE.
    eu_issue_ready = 2'b00;
    send(K_ALU, 3'd1, 4'd2);
    check("pre_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_issue_valid", 32'(eu_issue_valid), 32'd0);
    check("post_rst_op_a_data", 32'(eu_op_a_data), 32'd0);
    eu_issue_ready = 2'b11; eu_result_tag = {4'd6, 4'd3};
    exp_q.push_back(mk(2'b01, 4'd0, 1'b1, 4'd0, 1'b1));
    send(K_ALU, 3'd0, 4'd0);
    wait_idle("idle_post_rst");

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rf_dispatch_controller.md
RF_DISPATCH_CONTROLLER -- requirements
Module: rf_dispatch_controller

Interface
REQ-001 SHALL have parameter REGISTER_COUNT, default 8, number of architectural registers (register 0 = ACC).
REQ-002 SHALL have parameter DATA_WIDTH, default 4, data word width.
REQ-003 SHALL have parameter CDB_TAG_WIDTH, default 4, CDB tag width, constrained to CDB_TAG_WIDTH<=DATA_WIDTH.
REQ-004 SHALL have parameter UOP_COMMAND_WIDTH, default 3, uop kind width.
REQ-005 SHALL have parameter EU_COUNT, default 2, number of ALU execution-unit issue ports.
REQ-006 SHALL provide ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cdb_in_valid / cdb_in_tag / cdb_in_data  in  1 / CDB_TAG_WIDTH / DATA_WIDTH  result broadcast.
- cmd_valid  in  1  decode offers a uop.
- cmd_ready  out  1  controller accepts the uop.
- cmd_kind / cmd_op1 / cmd_op2  in  UOP_COMMAND_WIDTH / clog2(REGISTER_COUNT) / max(DATA_WIDTH, clog2(REGISTER_COUNT))  uop fields.
- eu_issue_valid  out  EU_COUNT  one-hot issue request.
- eu_issue_ready  in  EU_COUNT  per-EU ready.
- eu_result_tag  in  EU_COUNT*CDB_TAG_WIDTH  tag EU i assigns to an accepted uop.
- eu_op_a_data / eu_op_b_data  out  DATA_WIDTH  operand data or tag, shared by all EUs.
- eu_op_a_valid / eu_op_b_valid  out  1  operand holds data (1) or pending tag (0).

Function
REQ-007 Each register SHALL store a value field and a valid flag; when valid=0 the value field holds a pending CDB tag.
REQ-008 The FSM SHALL have states IDLE and ISSUE; cmd_ready SHALL equal (state==IDLE).
REQ-009 A uop SHALL be accepted on a cycle where cmd_valid and cmd_ready are both 1.
REQ-010 On accepted NOP or an unknown kind, no state SHALL change.
REQ-011 On accepted IMM, the next edge SHALL write ACC = {cmd_op2 truncated to DATA_WIDTH, valid=1}.
REQ-012 On accepted COPY, the next edge SHALL write register cmd_op2 with the value and valid of register cmd_op1.
REQ-013 On accepted ALU, the next edge SHALL latch operand A from register cmd_op1 and operand B from register cmd_op2 into hold registers, and SHALL enter ISSUE.
REQ-014 In ISSUE, eu_issue_valid SHALL be one-hot on the first EU with ready=1, searching from the round-robin pointer upward with wrap; it SHALL be all zero if no EU is ready.
REQ-015 A transfer SHALL occur when valid and ready are both 1 for the selected EU. On transfer, the next edge SHALL write ACC = {eu_result_tag[i], valid=0}, set the pointer to i+1 mod EU_COUNT, and return to IDLE.
REQ-016 eu_op_* SHALL be driven from the hold registers in ISSUE and SHALL be 0 in IDLE.
REQ-017 CDB snoop: when cdb_in_valid=1, every register and every hold operand with valid=0 and a stored tag equal to cdb_in_tag SHALL take {cdb_in_data, valid=1} at the next edge.
REQ-018 Bypass: a COPY or ALU read of a register matched by the CDB in the same cycle SHALL return {cdb_in_data, valid=1}.
REQ-019 Collision: when a write-port update and a CDB update target the same register in the same cycle, the write-port update SHALL take effect.
REQ-020 While in ISSUE with no ready EU, the uop SHALL be held indefinitely; the hold operands SHALL continue to snoop the CDB.

Reset
REQ-021 While rst=1, all registers SHALL become {0, valid=1}, hold operands SHALL become {0, valid=1}, the FSM SHALL enter IDLE, and the pointer SHALL become 0.
REQ-022 After reset, outputs SHALL be cmd_ready=1, eu_issue_valid=0, eu_op_*=0.
REQ-023 Asserting reset while in ISSUE SHALL discard the held uop; no ACC write SHALL occur.

Structure
REQ-024 UOP_COMMAND_KIND_* constants SHALL come from the shared frontend package; FSM state encodings SHALL be added to the same package.
REQ-025 Round-robin selection SHALL be a sub-module named dispatch_rr_arbiter (inputs: ready vector, pointer; output: one-hot grant).

Verification
REQ-026 The bench SHALL cover: reset, then IMM op2=5 -> next cycle ACC={5, valid=1}, cmd_ready=1.
REQ-027 The bench SHALL cover: COPY r0->r3 after IMM 5 -> r3={5, 1}.
REQ-028 The bench SHALL cover: ALU r1,r2, EU0 ready=0 and EU1 ready=1, tag1=9 -> eu_issue_valid=2'b10, ACC={9, 0}, pointer=0.
REQ-029 The bench SHALL cover: ACC pending tag 9, then CDB tag=9 data=7 -> ACC={7, 1}; an ALU read of r0 in the same cycle sees {7, 1}.
REQ-030 The bench SHALL cover: ISSUE with both EUs not ready for 3 cycles while the CDB resolves a held tag -> cmd_ready=0 throughout, and the issued operand is valid with the CDB data.
REQ-031 The bench SHALL cover: rst pulse while in ISSUE -> IDLE, eu_issue_valid=0, ACC={0, 1}.
